adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit that succeeds the fixed 32-bit byte-ripple word adder. It splits a WIDTH-bit operation into STAGES = WIDTH/SLICE slices and computes one slice per clock, registering the carry between stages. Operands enter through a valid/ready handshake and results leave through one, so a new operation can be issued every cycle. It sits between the ALU operand muxes and the writeback path, where long-width adds would otherwise limit clock frequency.

---
 rtl/adder_pipe_if.sv | 57 +++++
 rtl/adder_pipe.sv | 151 +++++++++++++++
 tb/tb_adder_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// -----------------------------------------------------------------------------
// adder_pipe_if
//   Operand/result handshake bundle for the pipelined add/subtract unit.
//
//   Signals (direction as seen from the unit, i.e. the slave modport):
//     in_valid  in   operand beat valid
//     in_ready  out  unit can accept an operand beat this cycle
//     a, b      in   WIDTH-bit operands
//     carry_in  in   carry into bit 0 (add mode only)
//     sub       in   0 = a + b + carry_in, 1 = a - b
//     out_valid out  result beat valid
//     out_ready in   downstream accepts the result
//     sum       out  WIDTH-bit result
//     carry_out out  carry out of the MSB (subtract: 1 = no borrow)
//
//   When ADDER_PIPE_FLAGS_EN is defined, the bundle also carries
//   flag_zero, flag_neg and flag_ovf (outputs of the unit).
// -----------------------------------------------------------------------------
interface adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef ADDER_PIPE_FLAGS_EN
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_ovf;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, flag_zero, flag_neg, flag_ovf
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, flag_zero, flag_neg, flag_ovf
  );
`else
  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
`endif
endinterface

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//   Pipelined WIDTH-bit add/subtract unit. The operation is cut into
//   STAGES = WIDTH/SLICE slices; stage k adds slice k and registers the carry
//   for stage k+1. One operation can be issued per clock; latency is STAGES
//   clock edges counting the accept edge (STAGES = 1 is a registered adder).
//
//   Parameters:
//     WIDTH  operand/result width, positive multiple of SLICE
//     SLICE  bits summed per stage
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears all valid bits and the
//            result registers
//     bus    adder_pipe_if.slave (operand beat in, result beat out)
//
//   Optional feature: define ADDER_PIPE_FLAGS_EN to add the registered
//   flag_zero / flag_neg / flag_ovf outputs on the bus.
//
//   Flow control: the whole pipe advances when the output register is empty
//   or being drained (adv). Bubbles travel through and are not collapsed.
// -----------------------------------------------------------------------------
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / SLICE;

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
`ifdef ADDER_PIPE_FLAGS_EN
  logic             flag_zero_q;
  logic             flag_neg_q;
  logic             flag_ovf_q;
`endif

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;
`ifdef ADDER_PIPE_FLAGS_EN
  assign bus.flag_zero = flag_zero_q;
  assign bus.flag_neg  = flag_neg_q;
  assign bus.flag_ovf  = flag_ovf_q;
`endif

  // Each stage sees the partially computed result word (slices below k done,
  // slices k and up still raw operand a) plus the not-yet-consumed slices of
  // the second operand, shifted so the current slice sits at the bottom.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int XW = WIDTH - k * SLICE;

    logic [WIDTH-1:0] res_in;
    logic [XW-1:0]    bx_in;
    logic             c_in;
    logic             v_in;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] res_d;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + 1; carry_in is ignored in that mode.
      assign res_in = bus.a;
      assign bx_in  = bus.sub ? ~bus.b : bus.b;
      assign c_in   = bus.sub ? 1'b1 : bus.carry_in;
      assign v_in   = bus.in_valid;
    end else begin : g_chain
      assign res_in = g_stage[k-1].g_mid.res_q;
      assign bx_in  = g_stage[k-1].g_mid.bx_q;
      assign c_in   = g_stage[k-1].g_mid.c_q;
      assign v_in   = g_stage[k-1].g_mid.v_q;
    end

    assign slice_sum = {1'b0, res_in[LO +: SLICE]}
                     + {1'b0, bx_in[SLICE-1:0]}
                     + {{SLICE{1'b0}}, c_in};

    // NOTE: a combinational block assigns every output a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
      res_d               = res_in;
      res_d[LO +: SLICE]  = slice_sum[SLICE-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0]    res_q;
      logic [XW-SLICE-1:0] bx_q;
      logic                c_q;
      logic                v_q;

      // NOTE: registers update with non-blocking assignments so every stage
      // samples its neighbour's pre-edge value and the shift stays ordered.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_in;
        end
      end

      // NOTE: datapath registers are left without reset; the valid bit
      // already marks them as don't-care, so resetting them buys nothing.
      always_ff @(posedge clk) begin
        if (adv) begin
          res_q <= res_d;
          bx_q  <= bx_in[XW-1:SLICE];
          c_q   <= slice_sum[SLICE];
        end
      end
    end else begin : g_last
`ifdef ADDER_PIPE_FLAGS_EN
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      logic msb_cin;
      assign msb_cin = res_in[WIDTH-1] ^ bx_in[SLICE-1] ^ slice_sum[SLICE-1];
`endif

      // Output register: reset so sum/carry_out read 0 during reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          carry_q     <= 1'b0;
`ifdef ADDER_PIPE_FLAGS_EN
          flag_zero_q <= 1'b0;
          flag_neg_q  <= 1'b0;
          flag_ovf_q  <= 1'b0;
`endif
        end else if (adv) begin
          out_valid_q <= v_in;
          sum_q       <= res_d;
          carry_q     <= slice_sum[SLICE];
`ifdef ADDER_PIPE_FLAGS_EN
          flag_zero_q <= (res_d == '0);
          flag_neg_q  <= res_d[WIDTH-1];
          flag_ovf_q  <= msb_cin ^ slice_sum[SLICE];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//   Bench for adder_pipe with three instances: 32/8 (default), 16/4 and 8/8.
//   A per-instance scoreboard predicts results with plain modulo arithmetic
//   and checks them in FIFO order at every output handshake.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  adder_pipe_if #(.WIDTH(32)) bus32 ();
  adder_pipe_if #(.WIDTH(16)) bus16 ();
  adder_pipe_if #(.WIDTH(8))  bus8  ();

  adder_pipe #(.WIDTH(32), .SLICE(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  adder_pipe #(.WIDTH(16), .SLICE(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  adder_pipe #(.WIDTH(8),  .SLICE(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: w-bit modulo arithmetic; subtract carry means "no borrow".
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] full;
    logic        sa;
    logic        sb;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    if (sub) begin
      full = (aa - bb) & mask;
      r.co = (aa >= bb);
    end else begin
      full = aa + bb + {63'd0, cin};
      r.co = full[w];
    end
    r.sum = full[31:0] & mask[31:0];
    r.z   = (r.sum == 32'd0);
    r.n   = r.sum[w-1];
    sa    = aa[w-1];
    sb    = bb[w-1];
    r.v   = sub ? ((sa != sb) && (r.n != sa)) : ((sa == sb) && (r.n != sa));
    return r;
  endfunction

  // ---------------- scoreboards (sample on negedge) ----------------
  res_t        q32[$];
  res_t        q16[$];
  res_t        q8[$];
  res_t        e32;
  res_t        e16;
  res_t        e8;
  logic        stall32;
  logic        stall16;
  logic        stall8;
  logic [31:0] held32;
  logic [15:0] held16;
  logic [7:0]  held8;

  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      stall32 <= 1'b0;
    end else begin
      check("u32_ready", bus32.in_ready, !bus32.out_valid || bus32.out_ready);
      if (stall32 && bus32.out_valid) check("u32_hold", bus32.sum, held32);
      if (bus32.out_valid && bus32.out_ready) begin
        check("u32_nonempty", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          check("u32_sum", bus32.sum, e32.sum);
          check("u32_co", bus32.carry_out, e32.co);
`ifdef ADDER_PIPE_FLAGS_EN
          check("u32_flags", {bus32.flag_zero, bus32.flag_neg, bus32.flag_ovf}, {e32.z, e32.n, e32.v});
`endif
        end
      end
      if (bus32.in_valid && bus32.in_ready)
        q32.push_back(model(32, bus32.a, bus32.b, bus32.carry_in, bus32.sub));
      stall32 <= bus32.out_valid && !bus32.out_ready;
      held32  <= bus32.sum;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      stall16 <= 1'b0;
    end else begin
      check("u16_ready", bus16.in_ready, !bus16.out_valid || bus16.out_ready);
      if (stall16 && bus16.out_valid) check("u16_hold", bus16.sum, held16);
      if (bus16.out_valid && bus16.out_ready) begin
        check("u16_nonempty", q16.size() != 0, 1);
        if (q16.size() != 0) begin
          e16 = q16.pop_front();
          check("u16_sum", bus16.sum, e16.sum);
          check("u16_co", bus16.carry_out, e16.co);
`ifdef ADDER_PIPE_FLAGS_EN
          check("u16_flags", {bus16.flag_zero, bus16.flag_neg, bus16.flag_ovf}, {e16.z, e16.n, e16.v});
`endif
        end
      end
      if (bus16.in_valid && bus16.in_ready)
        q16.push_back(model(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.carry_in, bus16.sub));
      stall16 <= bus16.out_valid && !bus16.out_ready;
      held16  <= bus16.sum;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      stall8 <= 1'b0;
    end else begin
      check("u8_ready", bus8.in_ready, !bus8.out_valid || bus8.out_ready);
      if (stall8 && bus8.out_valid) check("u8_hold", bus8.sum, held8);
      if (bus8.out_valid && bus8.out_ready) begin
        check("u8_nonempty", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          check("u8_sum", bus8.sum, e8.sum);
          check("u8_co", bus8.carry_out, e8.co);
`ifdef ADDER_PIPE_FLAGS_EN
          check("u8_flags", {bus8.flag_zero, bus8.flag_neg, bus8.flag_ovf}, {e8.z, e8.n, e8.v});
`endif
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        q8.push_back(model(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.carry_in, bus8.sub));
      stall8 <= bus8.out_valid && !bus8.out_ready;
      held8  <= bus8.sum;
    end
  end

  // ---------------- helpers ----------------
  task automatic idle_all();
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.sub = 1'b0; bus32.carry_in = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.sub = 1'b0; bus16.carry_in = 1'b0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.sub  = 1'b0; bus8.carry_in  = 1'b0;
  endtask

  // One beat through the 32-bit unit with out_ready held high; lat counts
  // edges from the accept edge (1) to the first edge that shows out_valid.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sb, output res_t r, output int lat);
    bus32.a = a; bus32.b = b; bus32.carry_in = cin; bus32.sub = sb;
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 0;
    r   = '0;
    for (int n = 1; n <= 16; n++) begin
      if (bus32.out_valid) begin
        lat  = n;
        r.sum = bus32.sum;
        r.co  = bus32.carry_out;
`ifdef ADDER_PIPE_FLAGS_EN
        r.z = bus32.flag_zero; r.n = bus32.flag_neg; r.v = bus32.flag_ovf;
`endif
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  res_t r;
  int   lat;
  int   lat16;
  int   lat8;
  int   sent;
  int   got;
  int   acc32;
  int   acc16;
  int   acc8;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_all();
    bus32.in_valid = 1'b1; bus32.a = $urandom; bus32.b = $urandom;
    bus16.in_valid = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    bus8.in_valid  = 1'b1; bus8.a  = 8'($urandom);  bus8.b  = 8'($urandom);

    // Reset held with traffic offered: outputs stay cleared.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_valid32", bus32.out_valid, 0);
      check("rst_sum32", bus32.sum, 0);
      check("rst_co32", bus32.carry_out, 0);
      check("rst_valid16", bus16.out_valid, 0);
      check("rst_valid8", bus8.out_valid, 0);
`ifdef ADDER_PIPE_FLAGS_EN
      check("rst_flags32", {bus32.flag_zero, bus32.flag_neg, bus32.flag_ovf}, 0);
`endif
    end
    idle_all();
    rst_n = 1'b1;
    #1;
    check("rel_ready32", bus32.in_ready, 1);
    check("rel_ready16", bus16.in_ready, 1);
    check("rel_ready8", bus8.in_ready, 1);
    @(posedge clk); #1;

    // Directed 32-bit cases.
    run32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, r, lat);
    check("slice_carry_sum", r.sum, 32'h0000_0100);
    check("slice_carry_co", r.co, 0);
    check("lat32", lat, 4);

    run32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, r, lat);
    check("wrap_sum", r.sum, 32'h0);
    check("wrap_co", r.co, 1);
`ifdef ADDER_PIPE_FLAGS_EN
    check("wrap_zero", r.z, 1);
    check("wrap_ovf", r.v, 0);
`endif

    run32(32'd5, 32'd7, 1'b1, 1'b1, r, lat);
    check("sub_neg_sum", r.sum, 32'hFFFF_FFFE);
    check("sub_neg_co", r.co, 0);
`ifdef ADDER_PIPE_FLAGS_EN
    check("sub_neg_flag", r.n, 1);
`endif

    run32(32'h8000_0000, 32'd1, 1'b0, 1'b1, r, lat);
    check("sub_ovf_sum", r.sum, 32'h7FFF_FFFF);
    check("sub_ovf_co", r.co, 1);
`ifdef ADDER_PIPE_FLAGS_EN
    check("sub_ovf_flag", r.v, 1);
`endif

    // Latency of the other geometries (16/4 -> 4, 8/8 -> 1).
    @(posedge clk); #1;
    bus16.a = 16'h000F; bus16.b = 16'h0001; bus16.carry_in = 1'b0; bus16.sub = 1'b0;
    bus8.a  = 8'hF0;    bus8.b  = 8'h20;    bus8.carry_in  = 1'b1; bus8.sub  = 1'b0;
    bus16.in_valid = 1'b1;
    bus8.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
    lat16 = 0;
    lat8  = 0;
    for (int n = 1; n <= 12; n++) begin
      if (lat16 == 0 && bus16.out_valid) begin
        lat16 = n;
        check("w16_sum", bus16.sum, 16'h0010);
        check("w16_co", bus16.carry_out, 0);
      end
      if (lat8 == 0 && bus8.out_valid) begin
        lat8 = n;
        check("w8_sum", bus8.sum, 8'h11);
        check("w8_co", bus8.carry_out, 1);
      end
      @(posedge clk); #1;
    end
    check("lat16", lat16, 4);
    check("lat8", lat8, 1);

    // Back-pressure: 8 beats a=b=i, out_ready pattern 1,0,0 repeating.
    sent = 0;
    got  = 0;
    bus32.sub = 1'b0; bus32.carry_in = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      bus32.in_valid  = (sent < 8);
      bus32.a         = sent;
      bus32.b         = sent;
      bus32.out_ready = (cyc % 3 == 0);
      @(negedge clk);
      check("bp_in_ready", bus32.in_ready, !(bus32.out_valid && !bus32.out_ready));
      if (bus32.out_valid && bus32.out_ready) begin
        check("bp_result", bus32.sum, 2 * got);
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) sent++;
      @(posedge clk); #1;
    end
    check("bp_count", got, 8);
    idle_all();
    repeat (6) begin
      @(posedge clk); #1;
    end

    // Reset in the middle of a stalled, full pipe.
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    repeat (6) begin
      bus32.a = $urandom;
      bus32.b = $urandom;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus32.out_valid, 0);
    check("mid_rst_sum", bus32.sum, 0);
    check("mid_rst_co", bus32.carry_out, 0);
    @(posedge clk); #1;
    check("mid_rst_valid2", bus32.out_valid, 0);
    idle_all();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", bus32.in_ready, 1);
    repeat (8) begin
      @(posedge clk); #1;
      check("mid_no_ghost", bus32.out_valid, 0);
    end

    // Random traffic with random back-pressure on all three units.
    acc32 = 0;
    acc16 = 0;
    acc8  = 0;
    fork
      begin
        for (int cyc = 0; cyc < 6000 && acc32 < 1000; cyc++) begin
          bus32.in_valid = ($urandom_range(0, 3) != 0);
          bus32.a = $urandom; bus32.b = $urandom;
          bus32.carry_in = 1'($urandom_range(0, 1)); bus32.sub = 1'($urandom_range(0, 1));
          bus32.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus32.in_valid && bus32.in_ready) acc32++;
          @(posedge clk); #1;
        end
      end
      begin
        for (int cyc = 0; cyc < 6000 && acc16 < 1000; cyc++) begin
          bus16.in_valid = ($urandom_range(0, 3) != 0);
          bus16.a = 16'($urandom); bus16.b = 16'($urandom);
          bus16.carry_in = 1'($urandom_range(0, 1)); bus16.sub = 1'($urandom_range(0, 1));
          bus16.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus16.in_valid && bus16.in_ready) acc16++;
          @(posedge clk); #1;
        end
      end
      begin
        for (int cyc = 0; cyc < 6000 && acc8 < 1000; cyc++) begin
          bus8.in_valid = ($urandom_range(0, 3) != 0);
          bus8.a = 8'($urandom); bus8.b = 8'($urandom);
          bus8.carry_in = 1'($urandom_range(0, 1)); bus8.sub = 1'($urandom_range(0, 1));
          bus8.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus8.in_valid && bus8.in_ready) acc8++;
          @(posedge clk); #1;
        end
      end
    join
    check("rand_acc32", acc32, 1000);
    check("rand_acc16", acc16, 1000);
    check("rand_acc8", acc8, 1000);

    // Drain and confirm every predicted result came out.
    idle_all();
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("drain32", q32.size(), 0);
    check("drain16", q16.size(), 0);
    check("drain8", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
